// File: rtl/multicycle_controller_pkg.sv
// Shared types and encodings for the multicycle RV32I-subset controller:
// FSM states, opcodes, ALU operations and datapath mux selects.
package mc_pkg;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEMADR,
        MEMREAD,
        MEMWB,
        MEMWRITE,
        EXECR,
        EXECI,
        ALUWB,
        BRANCH,
        ILLEGAL
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;
    localparam logic [6:0] F7_ADD = 7'b0000000;
    localparam logic [6:0] F7_SUB = 7'b0100000;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;

    localparam logic [1:0] SRC_A_PC    = 2'b00;
    localparam logic [1:0] SRC_A_OLDPC = 2'b01;
    localparam logic [1:0] SRC_A_RS1   = 2'b10;

    localparam logic [1:0] SRC_B_RS2  = 2'b00;
    localparam logic [1:0] SRC_B_IMM  = 2'b01;
    localparam logic [1:0] SRC_B_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT  = 2'b00;
    localparam logic [1:0] RES_MEMDATA = 2'b01;
    localparam logic [1:0] RES_ALU     = 2'b10;

    // beq takes the branch on equality, bne on inequality
    function automatic logic branch_taken(input logic [2:0] funct3, input logic zero);
        return (funct3 == F3_BNE) ? !zero : zero;
    endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Bundle between the controller and the shared datapath: instruction/status
// inputs to the controller and every select and enable it drives back.
interface multicycle_controller_if;

    logic [31:0] instr;
    logic        zero;
    logic        mem_ready;

    logic        mem_req;
    logic        mem_write;
    logic        adr_src;
    logic        ir_write;
    logic        pc_write;
    logic        reg_write;
    logic [1:0]  alu_src_a;
    logic [1:0]  alu_src_b;
    logic [1:0]  result_src;
    logic [3:0]  alu_op;
    logic        illegal;

    modport master (
        input  instr, zero, mem_ready,
        output mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
               alu_src_a, alu_src_b, result_src, alu_op, illegal
    );

    modport slave (
        output instr, zero, mem_ready,
        input  mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
               alu_src_a, alu_src_b, result_src, alu_op, illegal
    );

endinterface

// File: rtl/multicycle_controller_alu_decode.sv
// Combinational ALU decode: picks the ALU operation for the current state and
// flags funct3/funct7 combinations the core does not implement.
module mc_alu_decode
    import mc_pkg::*;
(
    input  state_t     state,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output logic [3:0] alu_op,
    output logic       legal
);

    always_comb begin
        alu_op = ALU_ADD;
        legal  = 1'b1;
        case (state)
            EXECR: begin
                if ({funct7, funct3} == {F7_ADD, F3_ADD}) begin
                    alu_op = ALU_ADD;
                end else if ({funct7, funct3} == {F7_SUB, F3_ADD}) begin
                    alu_op = ALU_SUB;
                end else begin
                    legal = 1'b0;
                end
            end
            EXECI: begin
                legal = (funct3 == F3_ADD);
            end
            // Branch compares rs1 - rs2 even when funct3 turns out illegal
            BRANCH: begin
                alu_op = ALU_SUB;
                legal  = (funct3 == F3_BEQ) || (funct3 == F3_BNE);
            end
            default: begin
                alu_op = ALU_ADD;
                legal  = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle control FSM: sequences fetch/decode/execute/memory/writeback over
// a shared datapath and drives every mux select and write enable.
module multicycle_controller
    import mc_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    multicycle_controller_if.master  bus
);

    state_t      state_q;
    state_t      state_d;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [3:0]  dec_alu_op;
    logic        dec_legal;
    logic        unused_instr_fields;

    logic        mem_req;
    logic        mem_write;
    logic        adr_src;
    logic        ir_write;
    logic        pc_write;
    logic        reg_write;
    logic [1:0]  alu_src_a;
    logic [1:0]  alu_src_b;
    logic [1:0]  result_src;
    logic [3:0]  alu_op;
    logic        illegal;

    assign opcode = bus.instr[6:0];
    assign funct3 = bus.instr[14:12];
    assign funct7 = bus.instr[31:25];
    assign unused_instr_fields = ^{bus.instr[24:15], bus.instr[11:7]};

    mc_alu_decode u_alu_decode (
        .state  (state_q),
        .funct3 (funct3),
        .funct7 (funct7),
        .alu_op (dec_alu_op),
        .legal  (dec_legal)
    );

    // Memory states only advance on mem_ready; ILLEGAL only leaves via reset
    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:    state_d = bus.mem_ready ? DECODE : FETCH;
            DECODE: begin
                case (opcode)
                    OP_LOAD, OP_STORE: state_d = MEMADR;
                    OP_RTYPE:          state_d = EXECR;
                    OP_ITYPE:          state_d = EXECI;
                    OP_BRANCH:         state_d = BRANCH;
                    default:           state_d = ILLEGAL;
                endcase
            end
            MEMADR:   state_d = (opcode == OP_LOAD) ? MEMREAD : MEMWRITE;
            MEMREAD:  state_d = bus.mem_ready ? MEMWB : MEMREAD;
            MEMWB:    state_d = FETCH;
            MEMWRITE: state_d = bus.mem_ready ? FETCH : MEMWRITE;
            EXECR:    state_d = dec_legal ? ALUWB : ILLEGAL;
            EXECI:    state_d = dec_legal ? ALUWB : ILLEGAL;
            ALUWB:    state_d = FETCH;
            BRANCH:   state_d = dec_legal ? FETCH : ILLEGAL;
            ILLEGAL:  state_d = ILLEGAL;
            default:  state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = SRC_A_PC;
        alu_src_b  = SRC_B_RS2;
        result_src = RES_ALUOUT;
        alu_op     = ALU_ADD;
        illegal    = 1'b0;
        case (state_q)
            // PC+4 is computed every fetch cycle but only committed on ready
            FETCH: begin
                mem_req    = 1'b1;
                adr_src    = 1'b0;
                alu_src_a  = SRC_A_PC;
                alu_src_b  = SRC_B_FOUR;
                result_src = RES_ALU;
                ir_write   = bus.mem_ready;
                pc_write   = bus.mem_ready;
            end
            DECODE: begin
                alu_src_a = SRC_A_OLDPC;
                alu_src_b = SRC_B_IMM;
            end
            MEMADR: begin
                alu_src_a = SRC_A_RS1;
                alu_src_b = SRC_B_IMM;
            end
            MEMREAD: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
            end
            MEMWB: begin
                result_src = RES_MEMDATA;
                reg_write  = 1'b1;
            end
            MEMWRITE: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
                adr_src   = 1'b1;
            end
            EXECR: begin
                alu_src_a = SRC_A_RS1;
                alu_src_b = SRC_B_RS2;
                alu_op    = dec_alu_op;
            end
            EXECI: begin
                alu_src_a = SRC_A_RS1;
                alu_src_b = SRC_B_IMM;
                alu_op    = dec_alu_op;
            end
            ALUWB: begin
                result_src = RES_ALUOUT;
                reg_write  = 1'b1;
            end
            // Target sits in ALUOut from DECODE; ALU is busy comparing
            BRANCH: begin
                alu_src_a  = SRC_A_RS1;
                alu_src_b  = SRC_B_RS2;
                alu_op     = dec_alu_op;
                result_src = RES_ALUOUT;
                pc_write   = dec_legal & branch_taken(funct3, bus.zero);
            end
            ILLEGAL: begin
                illegal = 1'b1;
            end
            default: begin
                illegal = 1'b0;
            end
        endcase
    end

    assign bus.mem_req    = mem_req;
    assign bus.mem_write  = mem_write;
    assign bus.adr_src    = adr_src;
    assign bus.ir_write   = ir_write;
    assign bus.pc_write   = pc_write;
    assign bus.reg_write  = reg_write;
    assign bus.alu_src_a  = alu_src_a;
    assign bus.alu_src_b  = alu_src_b;
    assign bus.result_src = result_src;
    assign bus.alu_op     = alu_op;
    assign bus.illegal    = illegal;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: a per-cycle vector table of
// instruction sequences plus hand-written stall, trap and reset sequences.
module tb_multicycle_controller;

    typedef struct {
        logic        rst;
        logic [31:0] instr;
        logic        zero;
        logic        rdy;
        logic [16:0] exp;
        string       name;
    } vec_t;

    localparam logic [31:0] I_ADD   = 32'h002081B3;
    localparam logic [31:0] I_SUB   = 32'h402081B3;
    localparam logic [31:0] I_MUL   = 32'h022081B3;
    localparam logic [31:0] I_ADDI  = 32'h00500093;
    localparam logic [31:0] I_LW    = 32'h0080A283;
    localparam logic [31:0] I_SW    = 32'h0020A223;
    localparam logic [31:0] I_BEQ   = 32'h00208463;
    localparam logic [31:0] I_BNE   = 32'h00209463;
    localparam logic [31:0] I_BBAD  = 32'h0020A463;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_pass;
    int   ir_cnt;
    int   pc_cnt;
    vec_t vecs[$];

    multicycle_controller_if bus ();

    multicycle_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, a, b, result_src, alu_op, illegal}
    function automatic logic [16:0] pk(input logic mreq, input logic mw, input logic adr,
                                       input logic irw, input logic pcw, input logic rw,
                                       input logic [1:0] a, input logic [1:0] b,
                                       input logic [1:0] rs, input logic [3:0] op,
                                       input logic ill);
        return {mreq, mw, adr, irw, pcw, rw, a, b, rs, op, ill};
    endfunction

    function automatic logic [16:0] e_fetch(input logic r);
        return pk(1, 0, 0, r, r, 0, 2'b00, 2'b10, 2'b10, 4'h0, 0);
    endfunction
    function automatic logic [16:0] e_decode();
        return pk(0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 4'h0, 0);
    endfunction
    function automatic logic [16:0] e_memadr();
        return pk(0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 4'h0, 0);
    endfunction
    function automatic logic [16:0] e_memread();
        return pk(1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 4'h0, 0);
    endfunction
    function automatic logic [16:0] e_memwb();
        return pk(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b01, 4'h0, 0);
    endfunction
    function automatic logic [16:0] e_memwrite();
        return pk(1, 1, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 4'h0, 0);
    endfunction
    function automatic logic [16:0] e_execr(input logic [3:0] op);
        return pk(0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00, op, 0);
    endfunction
    function automatic logic [16:0] e_execi();
        return pk(0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 4'h0, 0);
    endfunction
    function automatic logic [16:0] e_aluwb();
        return pk(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 4'h0, 0);
    endfunction
    function automatic logic [16:0] e_branch(input logic p);
        return pk(0, 0, 0, 0, p, 0, 2'b10, 2'b00, 2'b00, 4'h1, 0);
    endfunction
    function automatic logic [16:0] e_illegal();
        return pk(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 4'h0, 1);
    endfunction

    function automatic vec_t mk(input logic rst, input logic [31:0] instr, input logic zero,
                                input logic rdy, input logic [16:0] exp, input string name);
        vec_t v;
        v.rst   = rst;
        v.instr = instr;
        v.zero  = zero;
        v.rdy   = rdy;
        v.exp   = exp;
        v.name  = name;
        return v;
    endfunction

    task automatic add_vec(input logic [31:0] instr, input logic zero, input logic rdy,
                           input logic [16:0] exp, input string name);
        vecs.push_back(mk(1'b0, instr, zero, rdy, exp, name));
    endtask

    task automatic apply_stimulus(input vec_t v);
        reset         = v.rst;
        bus.instr     = v.instr;
        bus.zero      = v.zero;
        bus.mem_ready = v.rdy;
    endtask

    task automatic check_output(input vec_t v);
        logic [16:0] act;
        #2;
        act = {bus.mem_req, bus.mem_write, bus.adr_src, bus.ir_write, bus.pc_write,
               bus.reg_write, bus.alu_src_a, bus.alu_src_b, bus.result_src,
               bus.alu_op, bus.illegal};
        ir_cnt += int'(bus.ir_write);
        pc_cnt += int'(bus.pc_write);
        n_checks++;
        if (act === v.exp) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: actual %05h required %05h", v.name, act, v.exp);
        end
    endtask

    task automatic check_value(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: actual %0d required %0d", name, act, exp);
        end
    endtask

    task automatic run_cycle(input vec_t v);
        apply_stimulus(v);
        check_output(v);
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks      = 0;
        n_pass        = 0;
        ir_cnt        = 0;
        pc_cnt        = 0;
        reset         = 1'b1;
        bus.instr     = 32'h0;
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b0;

        // Cycle-by-cycle table: each row is one clock of the FSM
        add_vec(I_ADD, 0, 0, e_fetch(0), "reset_fetch_idle");
        add_vec(I_ADD, 0, 1, e_fetch(1), "add_fetch");
        add_vec(I_ADD, 0, 1, e_decode(), "add_decode");
        add_vec(I_ADD, 0, 1, e_execr(4'h0), "add_execr");
        add_vec(I_ADD, 0, 1, e_aluwb(), "add_aluwb");
        add_vec(I_ADDI, 0, 1, e_fetch(1), "addi_fetch");
        add_vec(I_ADDI, 0, 1, e_decode(), "addi_decode");
        add_vec(I_ADDI, 0, 1, e_execi(), "addi_execi");
        add_vec(I_ADDI, 0, 1, e_aluwb(), "addi_aluwb");
        add_vec(I_SUB, 0, 1, e_fetch(1), "sub_fetch");
        add_vec(I_SUB, 0, 1, e_decode(), "sub_decode");
        add_vec(I_SUB, 0, 1, e_execr(4'h1), "sub_execr");
        add_vec(I_SUB, 0, 1, e_aluwb(), "sub_aluwb");
        add_vec(I_LW, 0, 1, e_fetch(1), "lw_fetch");
        add_vec(I_LW, 0, 1, e_decode(), "lw_decode");
        add_vec(I_LW, 0, 1, e_memadr(), "lw_memadr");
        add_vec(I_LW, 0, 0, e_memread(), "lw_memread_wait1");
        add_vec(I_LW, 0, 0, e_memread(), "lw_memread_wait2");
        add_vec(I_LW, 0, 1, e_memread(), "lw_memread_ready");
        add_vec(I_LW, 0, 1, e_memwb(), "lw_memwb");
        add_vec(I_SW, 0, 1, e_fetch(1), "sw_fetch");
        add_vec(I_SW, 0, 1, e_decode(), "sw_decode");
        add_vec(I_SW, 0, 1, e_memadr(), "sw_memadr");
        add_vec(I_SW, 0, 1, e_memwrite(), "sw_memwrite");
        add_vec(I_BEQ, 1, 1, e_fetch(1), "beq_fetch");
        add_vec(I_BEQ, 1, 1, e_decode(), "beq_decode");
        add_vec(I_BEQ, 1, 1, e_branch(1), "beq_taken");
        add_vec(I_BNE, 1, 1, e_fetch(1), "bne_fetch");
        add_vec(I_BNE, 1, 1, e_decode(), "bne_decode");
        add_vec(I_BNE, 1, 1, e_branch(0), "bne_not_taken");
        add_vec(I_BEQ, 0, 1, e_fetch(1), "beq_nt_fetch");
        add_vec(I_BEQ, 0, 1, e_decode(), "beq_nt_decode");
        add_vec(I_BEQ, 0, 1, e_branch(0), "beq_not_taken");
        add_vec(I_BBAD, 1, 1, e_fetch(1), "bbad_fetch");
        add_vec(I_BBAD, 1, 1, e_decode(), "bbad_decode");
        add_vec(I_BBAD, 1, 1, e_branch(0), "bbad_branch_no_pcw");
        add_vec(I_BBAD, 1, 1, e_illegal(), "bbad_illegal");
        add_vec(I_ADD, 1, 1, e_illegal(), "bbad_illegal_sticky");

        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            run_cycle(vecs[i]);
        end

        // Reset out of the trap state clears illegal
        run_cycle(mk(1, I_ADD, 0, 0, e_illegal(), "rst_in_illegal"));
        run_cycle(mk(0, I_ADD, 0, 0, e_fetch(0), "after_rst_illegal"));

        // Fetch stall: enables fire once, only on the ready cycle
        ir_cnt = 0;
        pc_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            run_cycle(mk(0, I_ADD, 0, 0, e_fetch(0), "fetch_stall"));
        end
        check_value("stall_no_ir_write", ir_cnt, 0);
        check_value("stall_no_pc_write", pc_cnt, 0);
        run_cycle(mk(0, I_ADD, 0, 1, e_fetch(1), "stall_fetch_ready"));
        run_cycle(mk(0, I_ADD, 0, 1, e_decode(), "stall_decode"));
        run_cycle(mk(0, I_ADD, 0, 1, e_execr(4'h0), "stall_execr"));
        run_cycle(mk(0, I_ADD, 0, 1, e_aluwb(), "stall_aluwb"));
        check_value("ir_write_pulses", ir_cnt, 1);
        check_value("pc_write_pulses", pc_cnt, 1);

        // mul traps in EXECR with no writeback, then stays trapped
        run_cycle(mk(0, I_MUL, 0, 1, e_fetch(1), "mul_fetch"));
        run_cycle(mk(0, I_MUL, 0, 1, e_decode(), "mul_decode"));
        run_cycle(mk(0, I_MUL, 0, 1, e_execr(4'h0), "mul_execr_no_wb"));
        for (int i = 0; i < 3; i++) begin
            run_cycle(mk(0, I_ADD, 1, 1, e_illegal(), "mul_illegal_sticky"));
        end
        run_cycle(mk(1, I_ADD, 0, 0, e_illegal(), "rst_in_illegal2"));
        run_cycle(mk(0, I_ADD, 0, 0, e_fetch(0), "after_rst_illegal2"));

        // Reset during a stalled store abandons it cleanly
        run_cycle(mk(0, I_SW, 0, 1, e_fetch(1), "sw2_fetch"));
        run_cycle(mk(0, I_SW, 0, 1, e_decode(), "sw2_decode"));
        run_cycle(mk(0, I_SW, 0, 1, e_memadr(), "sw2_memadr"));
        run_cycle(mk(0, I_SW, 0, 0, e_memwrite(), "sw2_memwrite_stall"));
        run_cycle(mk(1, I_SW, 0, 0, e_memwrite(), "sw2_memwrite_rst"));
        run_cycle(mk(0, I_SW, 0, 0, e_fetch(0), "sw2_after_rst"));
        run_cycle(mk(0, I_SW, 0, 1, e_fetch(1), "sw2_refetch"));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Control FSM for the multicycle RV32I-subset core: it sequences a shared datapath (one ALU, one unified memory port, instruction register, PC) through fetch, decode, execute, memory and writeback steps. It supports lw, sw, addi, add/sub, beq and bne. It sits beside the datapath and replaces the single-cycle decode path: it consumes the registered instruction, the ALU zero flag and the memory ready handshake, and drives every mux select and write enable.

## Interface
- No parameters.
- clk  in  1  core clock
- reset  in  1  synchronous, active-high
- instr  in  32  instruction register output; valid from DECODE onward
- zero  in  1  ALU result == 0
- mem_ready  in  1  memory completes current request this cycle
- mem_req  out  1  memory access request
- mem_write  out  1  store; only with mem_req
- adr_src  out  1  memory address: 0 = PC, 1 = ALUOut register
- ir_write  out  1  load instruction register and oldPC register
- pc_write  out  1  PC <= ALU result (FETCH) or ALUOut (BRANCH)
- reg_write  out  1  register file write
- alu_src_a  out  2  00 = PC, 01 = oldPC, 10 = rs1
- alu_src_b  out  2  00 = rs2, 01 = imm, 10 = const 4
- result_src  out  2  00 = ALUOut register, 01 = memory data register, 10 = ALU result
- alu_op  out  4  0000 = add, 0001 = sub
- illegal  out  1  unsupported instruction trapped

## Operation
- Registered state. Outputs are a combinational function of state, instr, zero and mem_ready.
- Any output not listed for a state is 0. alu_op defaults to add.
- FETCH: mem_req, adr_src=0, a=00, b=10, result_src=10. ir_write = pc_write = mem_ready. Stay in FETCH while !mem_ready; go to DECODE on mem_ready.
- DECODE: a=01, b=01, add (branch target into ALUOut). Next state by opcode:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BRANCH
  - else -> ILLEGAL
- MEMADR: a=10, b=01, add. Next: MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: mem_req, adr_src=1. Wait for mem_ready, then MEMWB.
- MEMWB: result_src=01, reg_write. Next: FETCH.
- MEMWRITE: mem_req, mem_write, adr_src=1. Wait for mem_ready, then FETCH.
- EXECR: a=10, b=00. Decode {funct7,funct3}:
  - 0000000_000 -> add
  - 0100000_000 -> sub
  - other -> ILLEGAL, no writeback
  - legal -> ALUWB
- EXECI: a=10, b=01. funct3=000 -> add, then ALUWB. Otherwise -> ILLEGAL.
- ALUWB: result_src=00, reg_write. Next: FETCH.
- BRANCH: a=10, b=00, sub, result_src=00.
  - funct3=000: pc_write=zero
  - funct3=001: pc_write=!zero
  - other -> ILLEGAL, pc_write=0
  - legal -> FETCH
- ILLEGAL: illegal=1, all other outputs 0. Held until reset.

## Timing
- Reset: state <= FETCH. illegal=0 after reset. With mem_ready=0, every output is 0 except FETCH's static selects (mem_req=1, b=10, result_src=10).
- Cycles per instruction with zero-wait memory (mem_ready=1 whenever mem_req):
  - beq/bne: 3
  - add/sub/addi/sw: 4
  - lw: 5
  - Each memory wait cycle adds 1 in FETCH, MEMREAD or MEMWRITE.
- Handshake: mem_req and adr_src are held stable until the mem_ready cycle. The state advances on that edge. mem_ready outside a request is ignored.
- ir_write and pc_write in FETCH fire in exactly the mem_ready cycle; exactly one PC+4 update per fetch.
- Reset mid-operation (e.g. during a stalled MEMWRITE): outputs follow the current state in the reset cycle. The next cycle is FETCH with no write enables. No partial writeback is ever issued after reset.
- Illegal trap: the trap decision cycle issues no reg_write or pc_write.

## Structure
- Package mc_pkg holds:
  - state_t enum (FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, ILLEGAL)
  - opcode constants
  - ALU_ADD / ALU_SUB
  - select encodings for alu_src_a, alu_src_b and result_src
- One combinational sub-module, mc_alu_decode, maps (state, funct3, funct7) to {alu_op, legal}.
- The FSM top holds the state register and the output logic.

## Test plan
- add x3,x1,x2 (0x002081B3), mem_ready=1 -> states FETCH, DECODE, EXECR, ALUWB. reg_write only in cycle 4, alu_op=0000 in EXECR.
- lw with mem_ready low 2 cycles in MEMREAD -> mem_req/adr_src=1 held 3 cycles. MEMWB at 7th cycle, result_src=01.
- beq taken (zero=1) and bne not taken (zero=1):
  - beq: pc_write=1 in BRANCH
  - bne: pc_write=0
  - both: alu_op=0001, 3 cycles each
- sub (funct7=0100000) -> alu_op=0001. funct7=0000001 (mul) -> ILLEGAL, illegal=1 sticky, no reg_write.
- Fetch stall: mem_ready=0 for 5 cycles -> ir_write=pc_write=0 throughout. Both pulse exactly once on ready.
- Reset asserted in stalled MEMWRITE -> next cycle FETCH, mem_write=0. Reset asserted in ILLEGAL -> illegal=0.
